ripple_counter: RTL and testbench

RIPPLE_COUNTER -- requirements
Module: ripple_counter

---
 rtl/ripple_counter_pkg.sv | 15 +
 rtl/counter_stage.sv | 21 ++
 rtl/ripple_counter.sv | 37 +++
 tb/tb_ripple_counter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ripple_counter_pkg.sv
// Shared constants and helpers for the ripple_counter block.
// Holds the default counter width and the terminal-count function.
package ripple_counter_pkg;

    localparam int COUNT_W_DEFAULT = 3;
    localparam int COUNT_W_MAX     = 16;

    // Largest value a WIDTH-bit counter reaches before wrapping to zero.
    function automatic logic [COUNT_W_MAX-1:0] max_count(input int unsigned width);
        logic [COUNT_W_MAX:0] full_v;
        full_v = (17'd1 << width) - 17'd1;
        return full_v[COUNT_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/counter_stage.sv
// Single toggle flip-flop stage of the ripple_counter chain.
// Synchronous active-low reset; toggles on a clk edge when t is high.
module counter_stage (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Toggle state register with reset taking priority over the toggle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/ripple_counter.sv
// Modulo-2^WIDTH up counter built from a chain of toggle stages.
// Every stage runs on clk; the carry is a toggle-enable chain, not a clock.
module ripple_counter
    import ripple_counter_pkg::*;
#(
    parameter int WIDTH = COUNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] t_s;

    assign t_s[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            // Stage i flips only when all lower stages are 1.
            if (i > 0) begin : g_enable
                assign t_s[i] = t_s[i-1] & q_s[i-1];
            end

            counter_stage u_stage (
                .clk (clk),
                .rst (rst),
                .t   (t_s[i]),
                .q   (q_s[i])
            );
        end
    endgenerate

    assign data_out = q_s;

endmodule

// File: tb/tb_ripple_counter.sv
// Directed self-checking bench for ripple_counter (WIDTH=3 and WIDTH=4).
// Expected values are hand-computed constants or a simple increment model.
module tb_ripple_counter;
    import ripple_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       rst4;
    logic [2:0] data_out;
    logic [3:0] data_out4;

    int checks;
    int failures;

    ripple_counter dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out)
    );

    ripple_counter #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst4),
        .data_out (data_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0]  seq3 [10];
        logic [3:0]  exp4;
        logic [3:0]  prev4;
        logic [15:0] top4;
        checks   = 0;
        failures = 0;
        seq3 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        rst  = 1'b0;
        rst4 = 1'b0;

        // Reset held for two edges.
        tick();
        check("reset_edge1", {13'd0, data_out}, 16'd0);
        tick();
        check("reset_edge2", {13'd0, data_out}, 16'd0);

        // Free count through a wrap.
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("count_step%0d", k), {13'd0, data_out}, {13'd0, seq3[k]});
        end

        // Reset mid-count at 5.
        tick();
        tick();
        tick();
        check("reach5", {13'd0, data_out}, 16'd5);
        rst = 1'b0;
        tick();
        check("reset_at5", {13'd0, data_out}, 16'd0);
        rst = 1'b1;
        tick();
        check("release_after5", {13'd0, data_out}, 16'd1);

        // Reset on the wrap edge beats the wrap.
        for (int k = 0; k < 6; k++) tick();
        check("reach7", {13'd0, data_out}, max_count(3));
        rst = 1'b0;
        tick();
        check("reset_at7", {13'd0, data_out}, 16'd0);
        rst = 1'b1;
        tick();
        check("release_after7", {13'd0, data_out}, 16'd1);

        // Reset pulse between edges must be ignored.
        tick();
        tick();
        check("reach3", {13'd0, data_out}, 16'd3);
        #2 rst = 1'b0;
        #1;
        check("no_async_reset", {13'd0, data_out}, 16'd3);
        #1 rst = 1'b1;
        tick();
        check("pulse_ignored", {13'd0, data_out}, 16'd4);

        // Holding reset keeps the count at zero.
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold_reset%0d", k), {13'd0, data_out}, 16'd0);
        end
        rst = 1'b1;
        tick();
        check("release_after_hold", {13'd0, data_out}, 16'd1);

        // WIDTH=4: 17 edges from reset, per-bit toggle period 2^i.
        tick();
        check("w4_reset", {12'd0, data_out4}, 16'd0);
        rst4 = 1'b1;
        exp4 = 4'd0;
        top4 = 16'd0;
        for (int k = 1; k <= 17; k++) begin
            prev4 = data_out4;
            exp4  = exp4 + 4'd1;
            tick();
            check($sformatf("w4_edge%0d", k), {12'd0, data_out4}, {12'd0, exp4});
            for (int b = 0; b < 4; b++) begin
                check($sformatf("w4_bit%0d_edge%0d", b, k),
                      {15'd0, data_out4[b] ^ prev4[b]},
                      {15'd0, ((k % (1 << b)) == 0)});
            end
            if (k == 15) top4 = {12'd0, data_out4};
        end
        check("w4_max", top4, 16'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
